// File: rtl/csd2bin_pipe.sv
// Pipelined borrow-save (CSD) to two's complement converter.
// Segment k is summed in stage k; the word rides along the pipe so all result bits leave together.
module csd2bin_pipe #(
  parameter int unsigned W   = 64,
  parameter int unsigned S   = 4,
  parameter int unsigned SAT = 0
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   y,
  output logic           ovf
);

  localparam int unsigned G = W / S;

  // Stage k register: r holds result bits for segments 0..k and raw data bits above,
  // s holds the sign bits still to be consumed, c is the carry out of segment k.
  logic           v_q   [S];
  logic           c_q   [S];
  logic [W-1:0]   r_q   [S];
  logic [W-1:0]   s_q   [S];
  logic           ovf_q;

  logic           v_d   [S];
  logic           c_d   [S];
  logic [W-1:0]   r_d   [S];
  logic [W-1:0]   s_d   [S];
  logic           ovf_d;

  logic           src_v [S];
  logic           src_c [S];
  logic [W-1:0]   src_r [S];
  logic [W-1:0]   src_s [S];

  logic           en;

  assign en       = out_ready | ~v_q[S-1];
  assign in_ready = en;

  // Stage inputs: stage 0 splits the digit pairs with carry-in 1, later stages read their predecessor.
  always_comb begin
    for (int k = 0; k < S; k++) begin
      src_v[k] = 1'b0;
      src_c[k] = 1'b0;
      src_r[k] = '0;
      src_s[k] = '0;
    end
    src_v[0] = in_valid;
    src_c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      src_r[0][i] = x[2*i];
      src_s[0][i] = x[2*i+1];
    end
    for (int k = 1; k < S; k++) begin
      src_v[k] = v_q[k-1];
      src_c[k] = c_q[k-1];
      src_r[k] = r_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  // Per-segment d + ~s + carry; the last stage also derives overflow and optional saturation.
  always_comb begin
    logic [G:0]   seg;
    logic [G-1:0] dseg;
    logic [G-1:0] nseg;
    logic         yw;
    seg   = '0;
    dseg  = '0;
    nseg  = '0;
    yw    = 1'b0;
    ovf_d = 1'b0;
    for (int k = 0; k < S; k++) begin
      v_d[k] = src_v[k];
      s_d[k] = src_s[k];
      r_d[k] = src_r[k];
      dseg   = src_r[k][k*G +: G];
      nseg   = ~src_s[k][k*G +: G];
      seg    = {1'b0, dseg} + {1'b0, nseg} + {{G{1'b0}}, src_c[k]};
      r_d[k][k*G +: G] = seg[G-1:0];
      c_d[k] = seg[G];
    end
    yw    = ~c_d[S-1];
    ovf_d = yw ^ r_d[S-1][W-1];
    if ((SAT != 0) && ovf_d) begin
      r_d[S-1] = yw ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Whole pipe advances together; a stall freezes every stage including the output.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        r_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        r_q[k] <= r_d[k];
        s_q[k] <= s_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[S-1];
  assign y         = r_q[S-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csd2bin_pipe.sv
// Bench for csd2bin_pipe: five W=8 instances (S=2 wrap/saturate, S=1, S=4, S=8)
// checked against a digit-sum arithmetic model.
module tb_csd2bin_pipe;

  localparam int N = 5;
  localparam int unsigned S_TAB   [N] = '{2, 2, 1, 4, 8};
  localparam int unsigned SAT_TAB [N] = '{0, 1, 0, 0, 0};

  logic        clk = 1'b0;
  logic        arst;
  logic        iv   [N];
  logic [15:0] xi   [N];
  logic        ordy [N];
  logic        irdy [N];
  logic        ov   [N];
  logic        of   [N];
  logic [7:0]  yo   [N];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    csd2bin_pipe #(.W(8), .S(S_TAB[g]), .SAT(SAT_TAB[g])) u_dut (
      .clk      (clk),
      .arst     (arst),
      .in_valid (iv[g]),
      .in_ready (irdy[g]),
      .x        (xi[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .y        (yo[g]),
      .ovf      (of[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value is the plain signed sum of digit weights; range check decides overflow.
  function automatic logic [8:0] model(input logic [15:0] xv, input int unsigned sat);
    int         val;
    logic       o;
    logic [7:0] yy;
    val = 0;
    for (int i = 0; i < 8; i++) val += (int'(xv[2*i]) - int'(xv[2*i+1])) * (1 << i);
    o = (val > 127) || (val < -128);
    if (o && sat != 0) yy = (val > 0) ? 8'h7F : 8'h80;
    else               yy = 8'(val);
    return {o, yy};
  endfunction

  task automatic send_one(input int idx, input logic [15:0] xv, input logic [8:0] exp, input string tag);
    int   n;
    logic seen;
    @(negedge clk);
    ordy[idx] = 1'b1;
    xi[idx]   = xv;
    iv[idx]   = 1'b1;
    seen = 1'b0;
    n    = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      iv[idx] = 1'b0;
      if (ov[idx]) begin
        seen = 1'b1;
        n    = c;
      end
    end
    check({tag, "_latency"}, n, S_TAB[idx]);
    if (seen) begin
      check({tag, "_y"}, yo[idx], exp[7:0]);
      check({tag, "_ovf"}, of[idx], exp[8]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur;
    logic        pend;
    logic        prev_stall;
    logic [8:0]  held;
    logic [8:0]  e;
    logic [8:0]  q[$];
    logic [15:0] fixed [5];
    int          sent, got, stale;

    arst = 1'b1;
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; xi[i] = '0; ordy[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_out_valid", ov[i], 0);
      check("rst_in_ready", irdy[i], 1);
    end
    check("rst_y", yo[0], 0);
    check("rst_ovf", of[0], 0);
    repeat (3) @(negedge clk);
    arst = 1'b0;

    // Directed corner words on the wrapping and saturating S=2 instances.
    send_one(0, 16'h0009, {1'b0, 8'hFF}, "wrap_0009");
    send_one(0, 16'h0000, {1'b0, 8'h00}, "wrap_0000");
    send_one(0, 16'hFFFF, {1'b0, 8'h00}, "wrap_FFFF");
    send_one(0, 16'h5555, {1'b1, 8'hFF}, "wrap_5555");
    send_one(0, 16'hAAAA, {1'b1, 8'h01}, "wrap_AAAA");
    send_one(1, 16'h5555, {1'b1, 8'h7F}, "sat_5555");
    send_one(1, 16'hAAAA, {1'b1, 8'h80}, "sat_AAAA");
    send_one(1, 16'h0009, {1'b0, 8'hFF}, "sat_0009");

    // Segment-count sweep: corner words then random digit mixes.
    fixed = '{16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF, 16'h0009};
    for (int idx = 2; idx < N; idx++) begin
      for (int j = 0; j < 5; j++) send_one(idx, fixed[j], model(fixed[j], 0), "sweep_fixed");
      for (int j = 0; j < 12; j++) begin
        cur = 16'($urandom);
        send_one(idx, cur, model(cur, 0), "sweep_rand");
      end
    end

    // Random stream with bubbles and backpressure on instance 0.
    sent = 0; got = 0; pend = 1'b0; prev_stall = 1'b0; held = '0; cur = '0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", ov[0], 1);
        check("stall_hold", {of[0], yo[0]}, held);
      end
      ordy[0] = ($urandom_range(0, 2) != 0);
      if (!pend && sent < 16) begin
        pend = ($urandom_range(0, 3) != 0);
        cur  = 16'($urandom);
      end
      iv[0] = pend;
      xi[0] = cur;
      #1;
      if (ov[0] && ordy[0]) begin
        if (q.size() == 0) check("stream_extra", 1, 0);
        else begin
          e = q.pop_front();
          check("stream_y", yo[0], e[7:0]);
          check("stream_ovf", of[0], e[8]);
        end
        got++;
      end
      if (pend && irdy[0]) begin
        q.push_back(model(cur, 0));
        sent++;
        pend = 1'b0;
      end
      prev_stall = ov[0] && !ordy[0];
      held       = {of[0], yo[0]};
    end
    check("stream_count", got, 16);
    check("stream_left", q.size(), 0);
    @(negedge clk);
    iv[0] = 1'b0; ordy[0] = 1'b1;
    repeat (4) @(negedge clk);

    // Reset with two words in flight must flush them.
    ordy[0] = 1'b0; iv[0] = 1'b1; xi[0] = 16'h1234;
    @(negedge clk);
    xi[0] = 16'h0F0F;
    @(negedge clk);
    iv[0] = 1'b0;
    check("flight_valid", ov[0], 1);
    #1 arst = 1'b1;
    #1;
    check("arst_out_valid", ov[0], 0);
    check("arst_in_ready", irdy[0], 1);
    @(negedge clk);
    arst = 1'b0;
    ordy[0] = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) stale++;
    end
    check("no_stale", stale, 0);
    send_one(0, 16'h0009, {1'b0, 8'hFF}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csd2bin_pipe.md
CSD2BIN_PIPE -- requirements
Module: csd2bin_pipe

Interface -- parameters
REQ-001 SHALL have parameter W, default 64: result word width in bits; the input carries W borrow-save digits.
REQ-002 SHALL have parameter S, default 4: number of pipeline segments; W SHALL be an integer multiple of S, giving segment width G = W/S.
REQ-003 SHALL have parameter SAT, default 0: 0 = wrap on overflow, 1 = saturate on overflow.

Interface -- ports
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port arst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: input word valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the input word this cycle.
REQ-008 SHALL have port x, input, 2*W bits: CSD borrow-save word; digit i = {x[2i+1] sign bit s, x[2i] data bit d}.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port y, output, W bits: two's complement result.
REQ-012 SHALL have port ovf, output, 1 bit: result outside the W-bit two's complement range.

Function
REQ-013 SHALL compute value = sum over i of (d_i - s_i)*2^i, i.e. x^d + ~x^s + 1 with carry-in 1 at bit 0; digit codes 00 and 11 = 0, 01 = +1, 10 = -1.
REQ-014 SHALL process segment k (bits kG..kG+G-1) in pipeline stage k and register the carry out of each segment into stage k+1.
REQ-015 SHALL skew input segments forward and deskew result segments with delay registers, so that all W result bits of one word leave together.
REQ-016 SHALL form the extended result bit yW = NOT c[W]; ovf SHALL be 1 when yW differs from y[W-1].
REQ-017 With SAT=0, y SHALL be the low W bits of the result; with SAT=1 and ovf=1, y SHALL be 0x7F..F if yW=0, else 0x80..0; ovf SHALL be reported in both modes.
REQ-018 Latency SHALL be exactly S cycles from an accepted input (in_valid & in_ready) to out_valid, when no stall occurs.
REQ-019 Each stage SHALL carry a valid bit; stage valid, carry and data registers SHALL advance only when the pipeline is enabled.
REQ-020 The enable condition SHALL be: en = out_ready OR NOT out_valid; in_ready SHALL equal en, combinationally.
REQ-021 While en=0 (stall), all stages SHALL hold; y, ovf and out_valid SHALL stay stable until out_ready=1.
REQ-022 Throughput SHALL be one word per cycle when out_ready is held at 1; bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-023 With in_valid=1 and in_ready=0, the input SHALL NOT be consumed; the source keeps x stable.
REQ-024 Stages holding invalid data SHALL not affect y or ovf of valid words; y and ovf are don't-care while out_valid=0.
REQ-025 With S=1, the block SHALL degenerate to a single registered full-width conversion with latency 1.

Reset
REQ-026 On arst=1, all stage valid bits and out_valid SHALL clear to 0 immediately, and y, ovf and carries SHALL clear to 0.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight words; no result from before reset SHALL appear after reset.
REQ-028 in_ready SHALL be 1 during and after reset, since out_valid=0.
REQ-029 The first accepted word after reset release SHALL appear after exactly S cycles.

Verification (W=8, S=2 unless stated)
REQ-030 SHALL cover: x=16'h0009 (digit1 = -1, digit0 = +1) -> after 2 cycles y=8'hFF, ovf=0.
REQ-031 SHALL cover: x=16'h0000 and x=16'hFFFF -> y=8'h00, ovf=0 for both.
REQ-032 SHALL cover: x=16'h5555 (+255) -> SAT=0: y=8'hFF, ovf=1; SAT=1: y=8'h7F, ovf=1. x=16'hAAAA (-255) -> SAT=0: y=8'h01, ovf=1; SAT=1: y=8'h80, ovf=1.
REQ-033 SHALL cover: back-to-back stream of 16 random words with out_ready randomly toggled -> results in order, matching the reference model, none lost or duplicated, outputs stable during stalls.
REQ-034 SHALL cover: arst pulsed with 2 words in flight -> out_valid=0 immediately; no stale word appears afterwards; a new word's result appears 2 cycles after acceptance.
REQ-035 SHALL cover: S=1, S=4 and S=8 with W=8, exhaustive over all four digit codes per digit on a random sample -> latency equals S and results match the model.
